lut_stream_loader: RTL and testbench
====================================

Name: lut_stream_loader

Overview:
- Host-side initiator for the coprocessor's 64x8 lookup table write/read port.
- Moves a block of bytes from a host byte stream into consecutive LUT entries (LOAD), or reads consecutive entries back out as a byte stream (DUMP).
- Drives the table's shared write/read address, write enable and write data; samples its asynchronous read data.
- Sits between the host register interface (ZX-Uno port writes/reads) and the LUT.

Parameters:
- AW, 6, LUT address width (table depth 2**AW)
- DW, 8, LUT data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_load  in  1  one-cycle pulse; begin LOAD
- start_dump  in  1  one-cycle pulse; begin DUMP
- abort  in  1  one-cycle pulse; cancel the current operation
- base_addr  in  AW  first LUT entry, sampled on start
- length  in  AW+1  number of entries, 0..64, sampled on start
- in_data  in  DW  LOAD byte from host
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data
- out_data  out  DW  DUMP byte to host (registered)
- out_valid  out  1  out_data valid
- out_ready  in  1  host accepts out_data
- lut_load  out  1  LUT write enable
- lut_addr  out  AW  LUT write/read address
- lut_din  out  DW  LUT write data
- lut_dout  in  DW  LUT asynchronous read data at lut_addr
- busy  out  1  high while in LOAD or DUMP
- done  out  1  one-cycle pulse when an operation completes normally

Behaviour:
- Async reset: state IDLE; addr=0; remaining=0; out_data=0; out_valid=0; done=0; busy=0.
- lut_addr is always the internal addr register. lut_din is in_data (combinational).
- addr increments modulo 2**AW; 63 wraps to 0.
- States: IDLE, LOAD, DUMP. busy = (state != IDLE).
- IDLE:
  - start_load: addr<=base_addr, remaining<=length, enter LOAD.
  - start_dump: same register loads, enter DUMP.
  - Both starts in the same cycle: LOAD wins.
  - length=0: state stays IDLE, no LUT access, done pulses the next cycle.
- Starts are ignored while busy.
- LOAD:
  - in_ready=1. lut_load = in_valid (combinational); the write occurs at that clock edge.
  - On each handshake: addr++ and remaining--. When remaining goes 1->0, return to IDLE; done pulses in the IDLE cycle.
  - Throughput is one byte per cycle. in_ready=0 outside LOAD.
- DUMP:
  - lut_load=0 throughout.
  - First DUMP cycle: out_data<=lut_dout, out_valid<=1, addr++, remaining--.
  - While out_valid && !out_ready: out_data, out_valid and addr hold.
  - On out_valid && out_ready with remaining>0: the next entry is fetched in the same cycle (one byte per cycle).
  - On out_valid && out_ready with remaining=0: out_valid<=0, return to IDLE, done pulses.
- abort (any state, priority over everything except reset):
  - next state IDLE; out_valid<=0; no done pulse.
  - Writes already performed stay in the LUT. An abort in the same cycle as a LOAD handshake still performs that write.
- Reset mid-operation: immediate IDLE; lut_load drops asynchronously since in_ready=0 in IDLE.

Optional Feature:
- Macro: LUT_STREAM_LOADER_CHECKSUM_EN.
- When defined:
  - extra output port checksum [DW-1:0], reset 0, cleared on every accepted start.
  - In LOAD, checksum += in_data (mod 2**DW) on each handshake.
  - In DUMP, checksum += out_data on each out handshake.
  - Value is stable from the done pulse until the next start.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- LOAD base=62, length=4, bytes 11,22,33,44 with in_valid always high -> writes at addr 62,63,0,1; done 1 cycle after the 4th write; busy high exactly 4 cycles.
- DUMP base=62, length=4 after the above, out_ready toggling 1,0,0,1,1,1 -> out_data sequence 11,22,33,44, each held stable while stalled; no byte lost or duplicated; done after the 4th handshake.
- length=0 on start_load -> no lut_load, in_ready stays 0, done pulses the next cycle.
- start_load and start_dump in the same cycle (length=2) -> LOAD entered; a second start_dump while busy is ignored.
- LOAD length=8, abort after 3 bytes -> only 3 entries written, no done, IDLE next cycle; rst_n low mid-DUMP -> out_valid=0 and busy=0 immediately.
- With LUT_STREAM_LOADER_CHECKSUM_EN: LOAD bytes 0xF0,0x20,0x05 -> checksum=0x15; DUMP of the same entries -> checksum=0x15.

Source files
------------

// File: rtl/lut_stream_loader.sv
// Streams host bytes into consecutive LUT entries (LOAD) or reads them back as a byte stream (DUMP).
// Optional running byte checksum output enabled by defining LUT_STREAM_LOADER_CHECKSUM_EN.
module lut_stream_loader #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_load,
  input  logic          start_dump,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          lut_load,
  output logic [AW-1:0] lut_addr,
  output logic [DW-1:0] lut_din,
  input  logic [DW-1:0] lut_dout,
  output logic          busy,
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          in_hs;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign in_ready  = (state_q == LOAD);
  assign in_hs     = in_ready & in_valid;
  assign lut_load  = in_hs;
  assign lut_addr  = addr_q;
  assign lut_din   = in_data;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
  assign checksum  = csum_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if ((start_load || start_dump) && !abort) begin
          addr_d = base_addr;
          rem_d  = length;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (length == '0) begin
            done_d = 1'b1;
          end else if (start_load) begin
            state_d = LOAD;
          end else begin
            state_d = DUMP;
          end
        end
      end
      LOAD: begin
        if (in_hs) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (rem_q == {{AW{1'b0}}, 1'b1}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DUMP: begin
        // Advance on the first fetch or on a consumed byte; a stalled byte holds everything.
        if (!out_valid_q || out_ready) begin
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
          if (out_valid_q) begin
            csum_d = csum_q + out_data_q;
          end
`endif
          if (out_valid_q && (rem_q == '0)) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end else begin
            out_data_d  = lut_dout;
            out_valid_d = 1'b1;
            addr_d      = addr_q + 1'b1;
            rem_d       = rem_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides control only; a write handshaked this cycle still lands in the LUT.
    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_lut_stream_loader.sv
// Self-checking bench for lut_stream_loader: a 64x8 LUT model plus a reference image of its contents.
`timescale 1ns/1ps
module tb_lut_stream_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_load = 1'b0;
  logic       start_dump = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] length = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       lut_load;
  logic [5:0] lut_addr;
  logic [7:0] lut_din;
  logic [7:0] lut_dout;
  logic       busy;
  logic       done;
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] lut_mem [64];
  logic [7:0] ref_mem [64];
  logic [7:0] load_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (lut_load) lut_mem[lut_addr] <= lut_din;
  assign lut_dout = lut_mem[lut_addr];

  lut_stream_loader #(.AW(6), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump), .abort(abort),
    .base_addr(base_addr), .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .lut_load(lut_load), .lut_addr(lut_addr), .lut_din(lut_din), .lut_dout(lut_dout),
    .busy(busy),
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_load_q(input int unsigned n);
    load_q.delete();
    for (int unsigned i = 0; i < n; i++) load_q.push_back(8'($urandom));
  endtask

  task automatic check_mem();
    for (int unsigned i = 0; i < 64; i++) begin
      n_cmp++;
      if (lut_mem[i] !== ref_mem[i]) begin
        n_bad++; $display("FAIL mem[%0d]: got %h want %h", i, lut_mem[i], ref_mem[i]);
      end
    end
  endtask

  // LOAD of load_q at base; pvalid = percent chance in_valid is high (>=100 means always).
  task automatic do_load(input logic [5:0] base, input int unsigned pvalid);
    int unsigned len = load_q.size();
    int unsigned sent = 0;
    int unsigned cyc = 0;
    logic [5:0] a;
    logic [7:0] cs = 8'h00;
    @(negedge clk);
    base_addr = base; length = 7'(len); start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    while (sent < len && cyc < 4000) begin
      in_valid = (pvalid >= 100) || ($urandom_range(99) < pvalid);
      in_data  = load_q[sent];
      #1;
      a = base + 6'(sent);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy: got %b want 1", busy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL load_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (lut_load !== in_valid) begin n_bad++; $display("FAIL load_lut_load: got %b want %b", lut_load, in_valid); end
      n_cmp++; if (lut_addr !== a) begin n_bad++; $display("FAIL load_addr: got %0d want %0d", lut_addr, a); end
      if (in_valid) begin
        ref_mem[a] = load_q[sent];
        cs = cs + load_q[sent];
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (sent != len) begin n_bad++; $display("FAIL load_timeout: sent %0d want %0d", sent, len); end
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL load_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL load_end_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL load_end_in_ready: got %b want 0", in_ready); end
    if (pvalid >= 100) begin
      n_cmp++; if (cyc != len) begin n_bad++; $display("FAIL load_busy_cycles: got %0d want %0d", cyc, len); end
    end
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
    n_cmp++; if (checksum !== cs) begin n_bad++; $display("FAIL load_checksum: got %h want %h", checksum, cs); end
`endif
    @(negedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL load_done_pulse: got %b want 0", done); end
  endtask

  // DUMP of len entries at base; out_ready random (pready percent) or the stall pattern 1,0,0,1,1,1.
  task automatic do_dump(input logic [5:0] base, input int unsigned len, input int unsigned pready,
                         input bit use_pat);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int unsigned got = 0;
    int unsigned cyc = 0;
    int unsigned k = 0;
    logic [5:0] a;
    logic [7:0] cs = 8'h00;
    @(negedge clk);
    base_addr = base; length = 7'(len); start_dump = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start_dump = 1'b0;
    while (got < len && cyc < 4000) begin
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dump_busy: got %b want 1", busy); end
      n_cmp++; if (lut_load !== 1'b0) begin n_bad++; $display("FAIL dump_lut_load: got %b want 0", lut_load); end
      if (out_valid === 1'b1) begin
        a = base + 6'(got);
        n_cmp++; if (out_data !== ref_mem[a]) begin n_bad++; $display("FAIL dump_data[%0d]: got %h want %h", got, out_data, ref_mem[a]); end
        out_ready = use_pat ? ((k < 6) ? pat[k] : 1'b1) : ($urandom_range(99) < pready);
        k++;
        if (out_ready) begin
          cs = cs + ref_mem[a];
          got++;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++; if (got != len) begin n_bad++; $display("FAIL dump_timeout: got %0d bytes want %0d", got, len); end
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dump_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dump_end_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dump_end_valid: got %b want 0", out_valid); end
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
    n_cmp++; if (checksum !== cs) begin n_bad++; $display("FAIL dump_checksum: got %h want %h", checksum, cs); end
`endif
    @(negedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dump_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    n_cmp++; if (lut_addr !== 6'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", lut_addr); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_load();
    fill_load_q(64);
    do_load(6'($urandom), 70);
    check_mem();
  endtask

  task automatic test_load_wrap();
    load_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(6'd62, 100);
    check_mem();
  endtask

  task automatic test_dump_stall();
    do_dump(6'd62, 4, 100, 1'b1);
  endtask

  task automatic test_zero_length();
    @(negedge clk);
    base_addr = 6'($urandom); length = 7'd0; start_load = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clk);
    start_load = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (lut_load !== 1'b0) begin n_bad++; $display("FAIL zero_lut_load: got %b want 0", lut_load); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    check_mem();
  endtask

  task automatic test_both_starts();
    logic [5:0] b = 6'($urandom);
    logic [5:0] b1 = b + 6'd1;
    logic [7:0] d0 = 8'($urandom);
    logic [7:0] d1 = 8'($urandom);
    @(negedge clk);
    base_addr = b; length = 7'd2; start_load = 1'b1; start_dump = 1'b1;
    @(negedge clk);
    start_load = 1'b0; start_dump = 1'b1; base_addr = b + 6'd20; length = 7'd5;
    in_valid = 1'b1; in_data = d0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL both_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (lut_addr !== b) begin n_bad++; $display("FAIL both_addr0: got %0d want %0d", lut_addr, b); end
    ref_mem[b] = d0;
    @(negedge clk);
    start_dump = 1'b0; in_data = d1;
    #1;
    n_cmp++; if (lut_addr !== b1) begin n_bad++; $display("FAIL both_addr1: got %0d want %0d", lut_addr, b1); end
    ref_mem[b1] = d1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL both_done: got %b want 1", done); end
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL both_ignored_start: busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL both_out_valid: got %b want 0", out_valid); end
    check_mem();
  endtask

  task automatic test_abort();
    logic [5:0] b = 6'($urandom);
    logic [5:0] a;
    @(negedge clk);
    base_addr = b; length = 7'd8; start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      a = b + 6'(i);
      in_valid = 1'b1; in_data = 8'($urandom); abort = (i == 2);
      ref_mem[a] = in_data;
      @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    for (int unsigned i = 0; i < 4; i++) begin
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done[%0d]: got %b want 0", i, done); end
      @(negedge clk);
      #1;
    end
    check_mem();
  endtask

  task automatic test_random();
    for (int unsigned r = 0; r < 6; r++) begin
      fill_load_q($urandom_range(64, 1));
      do_load(6'($urandom), $urandom_range(100, 40));
      do_dump(6'($urandom), $urandom_range(64, 1), $urandom_range(100, 30), 1'b0);
    end
    check_mem();
  endtask

  task automatic test_reset_mid_dump();
    @(negedge clk);
    base_addr = 6'($urandom); length = 7'd8; start_dump = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start_dump = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_post_busy: got %b want 0", busy); end
  endtask

`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [5:0] b = 6'($urandom);
    load_q = '{8'hF0, 8'h20, 8'h05};
    do_load(b, 100);
    n_cmp++; if (checksum !== 8'h15) begin n_bad++; $display("FAIL csum_load: got %h want 15", checksum); end
    do_dump(b, 3, 60, 1'b0);
    n_cmp++; if (checksum !== 8'h15) begin n_bad++; $display("FAIL csum_dump: got %h want 15", checksum); end
    repeat (3) @(negedge clk);
    n_cmp++; if (checksum !== 8'h15) begin n_bad++; $display("FAIL csum_hold: got %h want 15", checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_load_wrap();
    test_dump_stall();
    test_zero_length();
    test_both_starts();
    test_abort();
    test_random();
    test_reset_mid_dump();
`ifdef LUT_STREAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
